// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types and helpers for the iterative shifter
//
// Purpose: mode and FSM state enumerations plus the legal-mode check used by
//          iter_shifter and shift_step.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_PASS = 3'b000,
        MODE_SRA  = 3'b001,
        MODE_SLL  = 3'b010,
        MODE_SRL  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_IL6  = 3'b110,
        MODE_IL7  = 3'b111
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shifter_state_e;

    // Encodings 110 and 111 are reserved; everything below is a real operation.
    function automatic logic is_legal_mode(input logic [2:0] mode);
        return (mode <= 3'b101);
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shift/rotate by 0..STEP bits
//
// Purpose: shifts data_i by k_i bits according to mode_i in one combinational
//          pass. Illegal modes and PASS return data_i unchanged.
// Ports:
//   data_i  [WIDTH-1:0]  operand
//   mode_i  shift_mode_e shift mode
//   k_i     [KW-1:0]     shift amount for this step, 0..STEP
//   data_o  [WIDTH-1:0]  shifted operand
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  shift_mode_e      mode_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] data_o
);

    // Complementary shift amount for rotates. When k_i is 0 this equals WIDTH,
    // and a shift by WIDTH yields zero, so the rotate degenerates to data_i.
    logic [31:0] rsh;

    always_comb begin
        rsh    = 32'(WIDTH) - 32'(k_i);
        data_o = data_i;
        case (mode_i)
            MODE_SRA: data_o = $signed(data_i) >>> k_i;
            MODE_SLL: data_o = data_i << k_i;
            MODE_SRL: data_o = data_i >> k_i;
            MODE_ROL: data_o = (data_i << k_i) | (data_i >> rsh);
            MODE_ROR: data_o = (data_i >> k_i) | (data_i << rsh);
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shifter, at most STEP bits per clock
//
// Purpose: accepts a (data, mode, amount) request, shifts it iteratively and
//          presents a registered result with zero/negative/illegal-mode flags.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_data/in_mode/in_amt     operand, mode, shift amount
//   out_valid/out_ready        result handshake
//   out_data                   shifted result
//   out_zero/out_neg/out_err   result == 0, result MSB, mode was illegal
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP   = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_mode,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_err
);

    localparam int KW = $clog2(STEP + 1);

    shifter_state_e   state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_zero_q;
    logic             out_neg_q;
    logic             out_err_q;
    logic [WIDTH-1:0] work_q;
    shift_mode_e      mode_q;
    logic [AMT_W-1:0] rem_q;

    logic             in_legal;
    logic [AMT_W-1:0] eff_amt;
    logic [KW-1:0]    step_k;
    logic [AMT_W-1:0] rem_d;
    logic [WIDTH-1:0] step_out;

    // PASS and illegal modes never shift, so they go straight to DONE.
    assign in_legal = is_legal_mode(in_mode);
    assign eff_amt  = (!in_legal || (in_mode == MODE_PASS)) ? '0 : in_amt;

    // k = min(remaining, STEP)
    always_comb begin
        if (int'(rem_q) < STEP) begin
            step_k = KW'(rem_q);
        end else begin
            step_k = KW'(STEP);
        end
        rem_d = rem_q - AMT_W'(step_k);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data_i (work_q),
        .mode_i (mode_q),
        .k_i    (step_k),
        .data_o (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
            out_neg_q   <= 1'b0;
            out_err_q   <= 1'b0;
            work_q      <= '0;
            mode_q      <= MODE_PASS;
            rem_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= in_data;
                        mode_q     <= shift_mode_e'(in_mode);
                        rem_q      <= eff_amt;
                        out_err_q  <= !in_legal;
                        in_ready_q <= 1'b0;
                        if (eff_amt == '0) begin
                            out_data_q  <= in_data;
                            out_zero_q  <= (in_data == '0);
                            out_neg_q   <= in_data[WIDTH-1];
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= step_out;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        out_data_q  <= step_out;
                        out_zero_q  <= (step_out == '0);
                        out_neg_q   <= step_out[WIDTH-1];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;
    assign out_neg   = out_neg_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - directed self-checking bench for iter_shifter
module tb_iter_shifter;

    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_mode;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic             out_err;

    int checks = 0;
    int failures = 0;

    iter_shifter #(.WIDTH(32), .STEP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  mode;
        logic [4:0]  amt;
        logic [31:0] exp_data;
        int          exp_n;
        logic        exp_zero;
        logic        exp_neg;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request at a negedge and let the next posedge accept it.
    // Inputs are left asserted; the caller decides when to drop in_valid.
    task automatic send(input logic [31:0] d, input logic [2:0] m, input logic [4:0] a);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_amt   = a;
        @(posedge clk);
    endtask

    // Count edges from acceptance until out_valid, sampling at negedges.
    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        send(v.data, v.mode, v.amt);
        #1;
        in_valid = 1'b0;
        in_data  = 32'h5A5A_5A5A;
        in_mode  = 3'b000;
        in_amt   = 5'd0;
        wait_valid(n);
        check({tag, "_latency"}, n, v.exp_n);
        check({tag, "_data"}, out_data, v.exp_data);
        check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, v.exp_zero});
        check({tag, "_neg"}, {31'd0, out_neg}, {31'd0, v.exp_neg});
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, v.exp_err});
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        handshake();
    endtask

    initial begin
        int n;
        logic [31:0] held;

        //          data          mode    amt    expected      N  z     n     e
        vecs[0]  = '{32'h0000_00FF, 3'b010, 5'd8,  32'h0000_FF00, 1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h8000_0000, 3'b001, 5'd31, 32'hFFFF_FFFF, 4, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h8000_0000, 3'b001, 5'd1,  32'hC000_0000, 1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h1234_5678, 3'b101, 5'd12, 32'h6781_2345, 2, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h1234_5678, 3'b100, 5'd12, 32'h4567_8123, 2, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'hCAFE_BABE, 3'b000, 5'd5,  32'hCAFE_BABE, 0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{32'hDEAD_BEEF, 3'b111, 5'd3,  32'hDEAD_BEEF, 0, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{32'h0000_0001, 3'b011, 5'd1,  32'h0000_0000, 1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'hF000_0000, 3'b011, 5'd28, 32'h0000_000F, 4, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'h8000_0001, 3'b100, 5'd9,  32'h0000_0300, 2, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'h0000_1234, 3'b010, 5'd0,  32'h0000_1234, 0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h0000_0000, 3'b110, 5'd0,  32'h0000_0000, 0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{32'h7FFF_FFFF, 3'b001, 5'd31, 32'h0000_0000, 4, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{32'h0000_0001, 3'b101, 5'd31, 32'h0000_0002, 4, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h0000_0001, 3'b010, 5'd16, 32'h0001_0000, 2, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_amt    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_flags", {29'd0, out_zero, out_neg, out_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: result must hold while a second request waits on in_valid.
        send(32'h0000_00FF, 3'b010, 5'd8);
        #1;
        in_data = 32'h0000_0100;
        in_mode = 3'b011;
        in_amt  = 5'd4;
        wait_valid(n);
        check("bp_latency", n, 1);
        held = out_data;
        check("bp_data", held, 32'h0000_FF00);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_data", out_data, 32'h0000_FF00);
            check("bp_hold_flags", {29'd0, out_zero, out_neg, out_err}, 32'd0);
            check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        // Held request is accepted on the following edge (IDLE with in_valid).
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(n);
        check("bp2_latency", n, 1);
        check("bp2_data", out_data, 32'h0000_0010);
        handshake();

        // Reset during SHIFT discards the operation.
        send(32'h0000_0001, 3'b010, 5'd31);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("midrst_idle_valid", {31'd0, out_valid}, 32'd0);
        end
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        run_vec('{32'h0000_0001, 3'b010, 5'd31, 32'h8000_0000, 4, 1'b0, 1'b1, 1'b0}, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised, multi-cycle successor to the MIC-1 datapath shifter. Sits between the ALU result and the C-bus.
- Supports six shift/rotate modes and a variable shift amount, processed at most STEP bits per clock.
- Valid/ready handshakes on input and output. Also produces zero, negative and illegal-mode flags for the control store.

Parameters:
- WIDTH, 32, data width; must be a power of two, >= 8.
- STEP, 8, maximum bits shifted per clock; 1 <= STEP <= WIDTH.
- AMT_W, $clog2(WIDTH), width of the shift-amount field (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  operand (ALU output).
- in_mode  input  3  shift mode; encodings under Behaviour.
- in_amt  input  AMT_W  shift amount, 0..WIDTH-1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0.
- out_neg  output  1  out_data[WIDTH-1].
- out_err  output  1  in_mode was illegal.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values:
  - state = IDLE; in_ready = 1 once reset deasserts.
  - out_valid = 0, out_data = 0, out_zero = 0, out_neg = 0, out_err = 0.
  - Internal remaining-count = 0.
- Mode encodings:
  - 000 PASS
  - 001 SRA (arithmetic right, sign fill)
  - 010 SLL (logical left)
  - 011 SRL (logical right)
  - 100 ROL
  - 101 ROR
  - 110, 111 illegal: result = in_data unshifted, out_err = 1.
- The legacy MIC-1 operations are SRA with amt=1 and SLL with amt=8.
- PASS ignores in_amt: remaining-count is loaded with 0.
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture data/mode/amt.
    - Go to DONE if effective amt == 0 or mode is illegal.
    - Otherwise go to SHIFT.
  - SHIFT: in_ready = 0. Each edge shifts the working register by k = min(remaining, STEP) per mode, and remaining -= k.
    - Go to DONE on the edge where remaining reaches 0.
  - DONE: out_valid = 1. Go to IDLE on out_valid & out_ready.
- Latency: out_valid is first high N = ceil(amt/STEP) edges after the acceptance edge.
  - N = 0 means out_valid is high in the cycle immediately after acceptance.
- Throughput: back-to-back requests are not overlapped.
  - in_ready is high only in IDLE.
  - Minimum request period is N + 2 cycles.
- Stability:
  - out_data and all flags are registered and stable while out_valid=1 and out_ready=0.
  - in_* changes after acceptance are ignored.
  - out_valid stays high indefinitely under backpressure.
- Result equivalence: the final result is identical to a single shift by amt.
  - SRA repeats sign-fill each step.
  - Rotates wrap modulo WIDTH.
- Flags: out_zero and out_neg are valid whenever out_valid=1 and are derived from the final out_data. out_err is cleared on the next acceptance.
- Reset mid-operation: asynchronous return to IDLE; all outputs take their reset values. The in-flight result is discarded.
- in_valid while not in IDLE: ignored, not queued; the producer must hold it.
- in_amt >= WIDTH cannot be encoded for a power-of-two WIDTH, so no clamping is needed.

Decomposition:
- Package shifter_pkg holds:
  - shift_mode_e enum (3-bit, encodings above);
  - shifter_state_e enum {IDLE, SHIFT, DONE};
  - function is_legal_mode().
- One combinational sub-module, shift_step. Parameters WIDTH and STEP.
  - Inputs: data, mode, k (0..STEP).
  - Output: data shifted by k per mode.
  - iter_shifter instantiates it once in the SHIFT datapath.

Test Plan (WIDTH=32, STEP=8):
- SLL in_data=0x0000_00FF, amt=8 -> out_data=0x0000_FF00, out_valid 1 edge after accept, zero=0, neg=0.
- SRA in_data=0x8000_0000, amt=31 -> out_data=0xFFFF_FFFF, N=4, neg=1; SRA 0x8000_0000 amt=1 -> 0xC000_0000 (legacy op).
- ROR in_data=0x1234_5678, amt=12 -> 0x6781_2345, N=2; ROL same operand amt=12 -> 0x4567_8123.
- PASS with in_amt=5 -> out_data=in_data, N=0; mode=111 with in_data=0xDEAD_BEEF -> out_data=0xDEAD_BEEF, out_err=1, N=0; SRL 0x0000_0001 amt=1 -> 0, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data/flags constant, in_ready=0, second in_valid ignored until handshake.
- Assert rst for 1 cycle during SHIFT (SLL amt=31) -> immediate out_valid=0, out_data=0, in_ready=1 after release; next request completes correctly.
